// File: rtl/qpu_exu_oitf_pkg.sv
// Shared widths and defaults for the outstanding-instruction track FIFO.
// Optional qubit-flag tracking is selected by QPU_OITF_QF_EN.
// Width macros are defined here only when the surrounding core has not set them.
`ifndef QPU_RFIDX_REAL_WIDTH
`define QPU_RFIDX_REAL_WIDTH 5
`endif
`ifndef QPU_QUBIT_NUM
`define QPU_QUBIT_NUM 4
`endif
`ifndef QPU_OITF_DEPTH
`define QPU_OITF_DEPTH 4
`endif
`ifndef QPU_OITF_PTR_W
`define QPU_OITF_PTR_W 2
`endif

package qpu_exu_oitf_pkg;
    localparam int OITF_DEPTH_DFLT = `QPU_OITF_DEPTH;
    localparam int PTR_W_DFLT      = `QPU_OITF_PTR_W;
    localparam int RFIDX_W_DFLT    = `QPU_RFIDX_REAL_WIDTH;
    localparam int QUBIT_W_DFLT    = `QPU_QUBIT_NUM;
endpackage

// File: rtl/qpu_exu_oitf_entry.sv
// One OITF entry: stores rd/qubit-flag info of an in-flight long-pipe op and emits its hazard terms.
// Latency: set/clear take effect on the next clk edge; match terms are combinational.
// No backpressure; set has priority over clear. Qubit storage exists only with QPU_OITF_QF_EN.
module qpu_exu_oitf_entry
    import qpu_exu_oitf_pkg::*;
#(
    parameter int RFIDX_W = RFIDX_W_DFLT,
    parameter int QUBIT_W = QUBIT_W_DFLT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               set_ena,
    input  logic               clr_ena,
    input  logic               set_rdwen,
    input  logic [RFIDX_W-1:0] set_rdidx,
    input  logic               set_qfren,
    input  logic [QUBIT_W-1:0] set_qubitlist,
    input  logic               disp_rs1en,
    input  logic               disp_rs2en,
    input  logic               disp_rdwen,
    input  logic               disp_qfren,
    input  logic [RFIDX_W-1:0] disp_rs1idx,
    input  logic [RFIDX_W-1:0] disp_rs2idx,
    input  logic [RFIDX_W-1:0] disp_rdidx,
    input  logic [QUBIT_W-1:0] disp_qubitlist,
    output logic               rdwen,
    output logic [RFIDX_W-1:0] rdidx,
    output logic               qfren,
    output logic [QUBIT_W-1:0] qubitlist,
    output logic               match_rs1,
    output logic               match_rs2,
    output logic               match_rd,
    output logic               match_qf
);

    logic               vld_q,   vld_d;
    logic               rdwen_q, rdwen_d;
    logic [RFIDX_W-1:0] rdidx_q, rdidx_d;

    // Next state of the register-tracking fields; a cleared entry is zeroed so
    // the retire-side view never shows stale data.
    always_comb begin
        vld_d   = vld_q;
        rdwen_d = rdwen_q;
        rdidx_d = rdidx_q;
        if (set_ena) begin
            vld_d   = 1'b1;
            rdwen_d = set_rdwen;
            rdidx_d = set_rdidx;
        end else if (clr_ena) begin
            vld_d   = 1'b0;
            rdwen_d = 1'b0;
            rdidx_d = '0;
        end
    end

    // Register-tracking state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            rdwen_q <= 1'b0;
            rdidx_q <= '0;
        end else begin
            vld_q   <= vld_d;
            rdwen_q <= rdwen_d;
            rdidx_q <= rdidx_d;
        end
    end

    assign rdwen     = rdwen_q;
    assign rdidx     = rdidx_q;
    assign match_rs1 = vld_q & rdwen_q & disp_rs1en & (rdidx_q == disp_rs1idx);
    assign match_rs2 = vld_q & rdwen_q & disp_rs2en & (rdidx_q == disp_rs2idx);
    assign match_rd  = vld_q & rdwen_q & disp_rdwen & (rdidx_q == disp_rdidx);

`ifdef QPU_OITF_QF_EN
    logic               qfren_q,     qfren_d;
    logic [QUBIT_W-1:0] qubitlist_q, qubitlist_d;

    // Next state of the qubit-flag fields, same set/clear priority as above.
    always_comb begin
        qfren_d     = qfren_q;
        qubitlist_d = qubitlist_q;
        if (set_ena) begin
            qfren_d     = set_qfren;
            qubitlist_d = set_qubitlist;
        end else if (clr_ena) begin
            qfren_d     = 1'b0;
            qubitlist_d = '0;
        end
    end

    // Qubit-flag state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qfren_q     <= 1'b0;
            qubitlist_q <= '0;
        end else begin
            qfren_q     <= qfren_d;
            qubitlist_q <= qubitlist_d;
        end
    end

    assign qfren     = qfren_q;
    assign qubitlist = qubitlist_q;
    assign match_qf  = vld_q & qfren_q & disp_qfren & (|(qubitlist_q & disp_qubitlist));
`else
    logic unused_qf_in;
    assign unused_qf_in = ^{set_qfren, set_qubitlist, disp_qfren, disp_qubitlist};
    assign qfren        = 1'b0;
    assign qubitlist    = '0;
    assign match_qf     = 1'b0;
`endif

endmodule

// File: rtl/qpu_exu_oitf.sv
// Outstanding Instruction Track FIFO: in-order alloc/retire of long-pipe ops plus RAW/WAW/qubit hazard flags.
// Latency: alloc visible to hazards/empty one cycle later; ret_* and match outputs are combinational.
// Backpressure: disp_oitf_ready=~full from registered pointers only. Qubit tracking gated by QPU_OITF_QF_EN.
module qpu_exu_oitf
    import qpu_exu_oitf_pkg::*;
#(
    parameter int OITF_DEPTH = OITF_DEPTH_DFLT,
    parameter int PTR_W      = PTR_W_DFLT,
    parameter int RFIDX_W    = RFIDX_W_DFLT,
    parameter int QUBIT_W    = QUBIT_W_DFLT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_oitf_ena,
    output logic               disp_oitf_ready,
    input  logic               disp_oitf_rs1en,
    input  logic               disp_oitf_rs2en,
    input  logic               disp_oitf_rdwen,
    input  logic               disp_oitf_qfren,
    input  logic [RFIDX_W-1:0] disp_oitf_rs1idx,
    input  logic [RFIDX_W-1:0] disp_oitf_rs2idx,
    input  logic [RFIDX_W-1:0] disp_oitf_rdidx,
    input  logic [QUBIT_W-1:0] disp_oitf_qubitlist,
    output logic               oitfrd_match_disprs1,
    output logic               oitfrd_match_disprs2,
    output logic               oitfrd_match_disprd,
    output logic               oitfqf_match_dispql,
    output logic [PTR_W-1:0]   dis_ptr,
    input  logic               oitf_ret_ena,
    output logic [PTR_W-1:0]   ret_ptr,
    output logic               ret_rdwen,
    output logic [RFIDX_W-1:0] ret_rdidx,
    output logic               ret_qfren,
    output logic [QUBIT_W-1:0] ret_qubitlist,
    output logic               oitf_empty
);

    logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
    logic             alloc_flg_q, alloc_flg_d;
    logic [PTR_W-1:0] ret_ptr_q,   ret_ptr_d;
    logic             ret_flg_q,   ret_flg_d;

    logic full;
    logic alloc_ena;
    logic retire_ena;

    // Equal pointers mean empty or full; the wrap flags tell which.
    assign oitf_empty      = (alloc_ptr_q == ret_ptr_q) & (alloc_flg_q == ret_flg_q);
    assign full            = (alloc_ptr_q == ret_ptr_q) & (alloc_flg_q != ret_flg_q);
    assign disp_oitf_ready = ~full;

    // Illegal requests are dropped so the pointers can never overrun each other.
    assign alloc_ena  = disp_oitf_ena & ~full;
    assign retire_ena = oitf_ret_ena & ~oitf_empty;

    // Pointer advance; each wrap from the last entry back to 0 toggles the flag.
    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        alloc_flg_d = alloc_flg_q;
        ret_ptr_d   = ret_ptr_q;
        ret_flg_d   = ret_flg_q;
        if (alloc_ena) begin
            if (alloc_ptr_q == PTR_W'(OITF_DEPTH - 1)) begin
                alloc_ptr_d = '0;
                alloc_flg_d = ~alloc_flg_q;
            end else begin
                alloc_ptr_d = alloc_ptr_q + PTR_W'(1);
            end
        end
        if (retire_ena) begin
            if (ret_ptr_q == PTR_W'(OITF_DEPTH - 1)) begin
                ret_ptr_d = '0;
                ret_flg_d = ~ret_flg_q;
            end else begin
                ret_ptr_d = ret_ptr_q + PTR_W'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr_q <= '0;
            alloc_flg_q <= 1'b0;
            ret_ptr_q   <= '0;
            ret_flg_q   <= 1'b0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            alloc_flg_q <= alloc_flg_d;
            ret_ptr_q   <= ret_ptr_d;
            ret_flg_q   <= ret_flg_d;
        end
    end

    assign dis_ptr = alloc_ptr_q;
    assign ret_ptr = ret_ptr_q;

    logic [OITF_DEPTH-1:0] rdwen_vec;
    logic [OITF_DEPTH-1:0] qfren_vec;
    logic [RFIDX_W-1:0]    rdidx_arr     [OITF_DEPTH];
    logic [QUBIT_W-1:0]    qubitlist_arr [OITF_DEPTH];
    logic [OITF_DEPTH-1:0] rs1_match_vec;
    logic [OITF_DEPTH-1:0] rs2_match_vec;
    logic [OITF_DEPTH-1:0] rd_match_vec;
    logic [OITF_DEPTH-1:0] qf_match_vec;

    for (genvar i = 0; i < OITF_DEPTH; i++) begin : g_entry
        qpu_exu_oitf_entry #(
            .RFIDX_W (RFIDX_W),
            .QUBIT_W (QUBIT_W)
        ) u_entry (
            .clk            (clk),
            .rst_n          (rst_n),
            .set_ena        (alloc_ena  & (alloc_ptr_q == PTR_W'(i))),
            .clr_ena        (retire_ena & (ret_ptr_q   == PTR_W'(i))),
            .set_rdwen      (disp_oitf_rdwen),
            .set_rdidx      (disp_oitf_rdidx),
            .set_qfren      (disp_oitf_qfren),
            .set_qubitlist  (disp_oitf_qubitlist),
            .disp_rs1en     (disp_oitf_rs1en),
            .disp_rs2en     (disp_oitf_rs2en),
            .disp_rdwen     (disp_oitf_rdwen),
            .disp_qfren     (disp_oitf_qfren),
            .disp_rs1idx    (disp_oitf_rs1idx),
            .disp_rs2idx    (disp_oitf_rs2idx),
            .disp_rdidx     (disp_oitf_rdidx),
            .disp_qubitlist (disp_oitf_qubitlist),
            .rdwen          (rdwen_vec[i]),
            .rdidx          (rdidx_arr[i]),
            .qfren          (qfren_vec[i]),
            .qubitlist      (qubitlist_arr[i]),
            .match_rs1      (rs1_match_vec[i]),
            .match_rs2      (rs2_match_vec[i]),
            .match_rd       (rd_match_vec[i]),
            .match_qf       (qf_match_vec[i])
        );
    end

    // Hazards are the OR of per-entry terms; a retiring entry still counts this cycle.
    assign oitfrd_match_disprs1 = |rs1_match_vec;
    assign oitfrd_match_disprs2 = |rs2_match_vec;
    assign oitfrd_match_disprd  = |rd_match_vec;

    assign ret_rdwen = rdwen_vec[ret_ptr_q];
    assign ret_rdidx = rdidx_arr[ret_ptr_q];

`ifdef QPU_OITF_QF_EN
    assign oitfqf_match_dispql = |qf_match_vec;
    assign ret_qfren           = qfren_vec[ret_ptr_q];
    assign ret_qubitlist       = qubitlist_arr[ret_ptr_q];
`else
    logic unused_qf_out;

    // Entries drive constant zeros here; fold them so nothing dangles.
    always_comb begin
        unused_qf_out = ^{qfren_vec, qf_match_vec};
        for (int i = 0; i < OITF_DEPTH; i++) begin
            unused_qf_out = unused_qf_out ^ (^qubitlist_arr[i]);
        end
    end

    assign oitfqf_match_dispql = 1'b0;
    assign ret_qfren           = 1'b0;
    assign ret_qubitlist       = '0;
`endif

endmodule

// File: tb/tb_qpu_exu_oitf.sv
// Bench for qpu_exu_oitf: directed alloc/retire/hazard sequence against hand-computed observations.
// Stimulus pushes the expected output snapshot; a negedge monitor pops and compares.
// Qubit-flag expectations collapse to zero unless QPU_OITF_QF_EN is defined.
module tb_qpu_exu_oitf;
    import qpu_exu_oitf_pkg::*;

    localparam int RW = RFIDX_W_DFLT;
    localparam int QW = QUBIT_W_DFLT;
    localparam int PW = PTR_W_DFLT;
    localparam int OW = 6 + 2 * PW + 1 + RW + 1 + QW;

    typedef logic [OW-1:0] obs_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          disp_oitf_ena;
    logic          disp_oitf_ready;
    logic          disp_oitf_rs1en, disp_oitf_rs2en, disp_oitf_rdwen, disp_oitf_qfren;
    logic [RW-1:0] disp_oitf_rs1idx, disp_oitf_rs2idx, disp_oitf_rdidx;
    logic [QW-1:0] disp_oitf_qubitlist;
    logic          oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd, oitfqf_match_dispql;
    logic [PW-1:0] dis_ptr;
    logic          oitf_ret_ena;
    logic [PW-1:0] ret_ptr;
    logic          ret_rdwen;
    logic [RW-1:0] ret_rdidx;
    logic          ret_qfren;
    logic [QW-1:0] ret_qubitlist;
    logic          oitf_empty;

    qpu_exu_oitf dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .disp_oitf_ena        (disp_oitf_ena),
        .disp_oitf_ready      (disp_oitf_ready),
        .disp_oitf_rs1en      (disp_oitf_rs1en),
        .disp_oitf_rs2en      (disp_oitf_rs2en),
        .disp_oitf_rdwen      (disp_oitf_rdwen),
        .disp_oitf_qfren      (disp_oitf_qfren),
        .disp_oitf_rs1idx     (disp_oitf_rs1idx),
        .disp_oitf_rs2idx     (disp_oitf_rs2idx),
        .disp_oitf_rdidx      (disp_oitf_rdidx),
        .disp_oitf_qubitlist  (disp_oitf_qubitlist),
        .oitfrd_match_disprs1 (oitfrd_match_disprs1),
        .oitfrd_match_disprs2 (oitfrd_match_disprs2),
        .oitfrd_match_disprd  (oitfrd_match_disprd),
        .oitfqf_match_dispql  (oitfqf_match_dispql),
        .dis_ptr              (dis_ptr),
        .oitf_ret_ena         (oitf_ret_ena),
        .ret_ptr              (ret_ptr),
        .ret_rdwen            (ret_rdwen),
        .ret_rdidx            (ret_rdidx),
        .ret_qfren            (ret_qfren),
        .ret_qubitlist        (ret_qubitlist),
        .oitf_empty           (oitf_empty)
    );

    always #5 clk = ~clk;

    obs_t obs;
    assign obs = {disp_oitf_ready, oitf_empty, oitfrd_match_disprs1, oitfrd_match_disprs2,
                  oitfrd_match_disprd, oitfqf_match_dispql, dis_ptr, ret_ptr,
                  ret_rdwen, ret_rdidx, ret_qfren, ret_qubitlist};

    obs_t  exp_q[$];
    string name_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    // Expected snapshot builder: ready, empty, rs1, rs2, rd, qf, dis_ptr, ret_ptr, ret_rdwen, ret_rdidx, ret_qfren, ret_qubitlist.
    function automatic obs_t mk(bit r, bit e, bit m1, bit m2, bit md, bit mq,
                                int dp, int rp, bit rw, int ri, bit qr, int ql);
`ifndef QPU_OITF_QF_EN
        mq = 1'b0;
        qr = 1'b0;
        ql = 0;
`endif
        return {r, e, m1, m2, md, mq, PW'(dp), PW'(rp), rw, RW'(ri), qr, QW'(ql)};
    endfunction

    task automatic chk(input string nm, input obs_t e);
        name_q.push_back(nm);
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        disp_oitf_ena       = 1'b0;
        disp_oitf_rs1en     = 1'b0;
        disp_oitf_rs2en     = 1'b0;
        disp_oitf_rdwen     = 1'b0;
        disp_oitf_qfren     = 1'b0;
        disp_oitf_rs1idx    = '0;
        disp_oitf_rs2idx    = '0;
        disp_oitf_rdidx     = '0;
        disp_oitf_qubitlist = '0;
        oitf_ret_ena        = 1'b0;
    endtask

    task automatic alloc(input bit rw, input int ri, input bit qf, input int ql);
        disp_oitf_ena       = 1'b1;
        disp_oitf_rdwen     = rw;
        disp_oitf_rdidx     = RW'(ri);
        disp_oitf_qfren     = qf;
        disp_oitf_qubitlist = QW'(ql);
    endtask

    // Monitor: compare every pending expectation against the DUT away from the active edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            obs_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", nm, obs, e);
            end
        end
    end

    // Protocol checks on the dispatch/retire handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            assert (!(disp_oitf_ena && !disp_oitf_ready)) else $error("alloc requested while full");
            assert (!(oitf_ret_ena && oitf_empty)) else $error("retire requested while empty");
        end
    end

    initial begin
        clr_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        cyc(); clr_in();
        chk("reset_idle", mk(1,1,0,0,0,0, 0,0, 0,0, 0,0));

        cyc(); clr_in(); alloc(1, 5, 0, 0);
        chk("alloc_not_bypassed", mk(1,1,0,0,0,0, 0,0, 0,0, 0,0));

        cyc(); clr_in(); disp_oitf_rs1en = 1'b1; disp_oitf_rs1idx = 5;
        chk("raw_rs1", mk(1,0,1,0,0,0, 1,0, 1,5, 0,0));

        cyc(); clr_in();
        disp_oitf_rs1en = 1'b1; disp_oitf_rs1idx = 5;
        disp_oitf_rs2en = 1'b1; disp_oitf_rs2idx = 5;
        disp_oitf_rdwen = 1'b1; disp_oitf_rdidx  = 5;
        oitf_ret_ena = 1'b1;
        chk("match_in_retire_cycle", mk(1,0,1,1,1,0, 1,0, 1,5, 0,0));

        cyc(); clr_in();
        disp_oitf_rs1en = 1'b1; disp_oitf_rs1idx = 5;
        disp_oitf_rs2en = 1'b1; disp_oitf_rs2idx = 5;
        disp_oitf_rdwen = 1'b1; disp_oitf_rdidx  = 5;
        chk("after_retire", mk(1,1,0,0,0,0, 1,1, 0,0, 0,0));

        // Fill all four slots starting at slot 1.
        cyc(); clr_in(); alloc(1, 10, 0, 0);
        chk("fill0", mk(1,1,0,0,0,0, 1,1, 0,0, 0,0));
        cyc(); clr_in(); alloc(1, 11, 0, 0);
        chk("fill1", mk(1,0,0,0,0,0, 2,1, 1,10, 0,0));
        cyc(); clr_in(); alloc(1, 12, 0, 0);
        chk("fill2", mk(1,0,0,0,0,0, 3,1, 1,10, 0,0));
        cyc(); clr_in(); alloc(1, 13, 0, 0);
        chk("fill3_wrap", mk(1,0,0,0,0,0, 0,1, 1,10, 0,0));

        cyc(); clr_in(); oitf_ret_ena = 1'b1; disp_oitf_rs1en = 1'b1; disp_oitf_rs1idx = 13;
        chk("full", mk(0,0,1,0,0,0, 1,1, 1,10, 0,0));

        cyc(); clr_in();
        chk("ready_after_full_retire", mk(1,0,0,0,0,0, 1,2, 1,11, 0,0));

        cyc(); clr_in(); oitf_ret_ena = 1'b1;
        chk("retire_to_two", mk(1,0,0,0,0,0, 1,2, 1,11, 0,0));

        // Occupancy 2: six cycles of simultaneous alloc and retire.
        cyc(); clr_in(); alloc(1, 20, 0, 0); oitf_ret_ena = 1'b1;
        chk("steady0", mk(1,0,0,0,0,0, 1,3, 1,12, 0,0));
        cyc(); clr_in(); alloc(1, 21, 0, 0); oitf_ret_ena = 1'b1;
        chk("steady1", mk(1,0,0,0,0,0, 2,0, 1,13, 0,0));
        cyc(); clr_in(); alloc(1, 22, 0, 0); oitf_ret_ena = 1'b1;
        chk("steady2", mk(1,0,0,0,0,0, 3,1, 1,20, 0,0));
        cyc(); clr_in(); alloc(1, 23, 0, 0); oitf_ret_ena = 1'b1;
        chk("steady3", mk(1,0,0,0,0,0, 0,2, 1,21, 0,0));
        cyc(); clr_in(); alloc(1, 24, 0, 0); oitf_ret_ena = 1'b1;
        chk("steady4", mk(1,0,0,0,0,0, 1,3, 1,22, 0,0));
        cyc(); clr_in(); alloc(1, 25, 0, 0); oitf_ret_ena = 1'b1;
        chk("steady5", mk(1,0,0,0,0,0, 2,0, 1,23, 0,0));

        cyc(); clr_in(); disp_oitf_rdwen = 1'b1; disp_oitf_rdidx = 25;
        chk("waw_after_steady", mk(1,0,0,0,1,0, 3,1, 1,24, 0,0));

        cyc(); clr_in(); oitf_ret_ena = 1'b1;
        chk("drain0", mk(1,0,0,0,0,0, 3,1, 1,24, 0,0));
        cyc(); clr_in(); oitf_ret_ena = 1'b1;
        chk("drain1", mk(1,0,0,0,0,0, 3,2, 1,25, 0,0));
        cyc(); clr_in();
        chk("drained_empty", mk(1,1,0,0,0,0, 3,3, 0,0, 0,0));

        // Qubit-flag overlap.
        cyc(); clr_in(); alloc(0, 0, 1, 4'b0110);
        chk("qf_alloc", mk(1,1,0,0,0,0, 3,3, 0,0, 0,0));
        cyc(); clr_in(); disp_oitf_qfren = 1'b1; disp_oitf_qubitlist = 4'b0100;
        chk("qf_overlap", mk(1,0,0,0,0,1, 0,3, 0,0, 1,4'b0110));
        cyc(); clr_in(); disp_oitf_qfren = 1'b1; disp_oitf_qubitlist = 4'b1001;
        chk("qf_disjoint", mk(1,0,0,0,0,0, 0,3, 0,0, 1,4'b0110));
        cyc(); clr_in(); disp_oitf_qubitlist = 4'b0110; disp_oitf_rs1en = 1'b1; disp_oitf_rs1idx = 0;
        chk("qf_disabled_no_rdwen", mk(1,0,0,0,0,0, 0,3, 0,0, 1,4'b0110));

        cyc(); clr_in(); alloc(1, 7, 0, 0);
        chk("fill_a", mk(1,0,0,0,0,0, 0,3, 0,0, 1,4'b0110));
        cyc(); clr_in(); alloc(1, 8, 0, 0);
        chk("fill_b", mk(1,0,0,0,0,0, 1,3, 0,0, 1,4'b0110));

        cyc(); clr_in();
        disp_oitf_rs1en = 1'b1; disp_oitf_rs1idx = 7;
        disp_oitf_qfren = 1'b1; disp_oitf_qubitlist = 4'b0010;
        chk("three_valid", mk(1,0,1,0,0,1, 2,3, 0,0, 1,4'b0110));

        // Asynchronous reset between edges, same dispatch inputs held.
        cyc(); rst_n = 1'b0;
        chk("async_reset", mk(1,1,0,0,0,0, 0,0, 0,0, 0,0));

        cyc(); rst_n = 1'b1; clr_in();
        chk("post_reset_idle", mk(1,1,0,0,0,0, 0,0, 0,0, 0,0));

        // Let the monitor drain, with a bound.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/qpu_exu_oitf.md
Name: QPU_exu_oitf

Overview:
Outstanding Instruction Track FIFO: the receiving end of the dispatch-to-OITF interface.
- Allocates one entry per dispatched long-pipe instruction (LSU/measure path) and holds it until its writeback retires it, in order.
- Gives dispatch combinational hazard flags: RAW/WAW on register indexes, and qubit-flag overlap on qubit lists.
- Sits beside the dispatch unit in the EXU; retire comes from the long-pipe writeback arbiter.

Parameters:
OITF_DEPTH, 4, number of entries; power of two, >=2.
PTR_W, log2(OITF_DEPTH), entry pointer width.
RFIDX_W, `QPU_RFIDX_REAL_WIDTH, register index width.
QUBIT_W, `QPU_QUBIT_NUM, qubit list width.

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
disp_oitf_ena  in  1  allocate an entry this cycle; legal only when disp_oitf_ready=1.
disp_oitf_ready  out  1  at least one free entry.
disp_oitf_rs1en  in  1  dispatching instruction reads rs1.
disp_oitf_rs2en  in  1  dispatching instruction reads rs2.
disp_oitf_rdwen  in  1  dispatching instruction writes rd.
disp_oitf_qfren  in  1  dispatching instruction sets/checks qubit flags.
disp_oitf_rs1idx  in  RFIDX_W  rs1 index.
disp_oitf_rs2idx  in  RFIDX_W  rs2 index.
disp_oitf_rdidx  in  RFIDX_W  rd index.
disp_oitf_qubitlist  in  QUBIT_W  qubit list.
oitfrd_match_disprs1  out  1  RAW hazard on rs1.
oitfrd_match_disprs2  out  1  RAW hazard on rs2.
oitfrd_match_disprd  out  1  WAW hazard on rd.
oitfqf_match_dispql  out  1  qubit-list overlap hazard.
dis_ptr  out  PTR_W  entry index the next allocation will take.
oitf_ret_ena  in  1  retire oldest entry; legal only when oitf_empty=0.
ret_ptr  out  PTR_W  index of the oldest entry.
ret_rdwen  out  1  oldest entry's rdwen.
ret_rdidx  out  RFIDX_W  oldest entry's rdidx.
ret_qfren  out  1  oldest entry's qfren.
ret_qubitlist  out  QUBIT_W  oldest entry's qubit list.
oitf_empty  out  1  no valid entries.

Behaviour:
- State:
  - alloc_ptr and ret_ptr, each PTR_W bits plus a wrap flag.
  - Per-entry vld bit and stored rdwen, rdidx, qfren, qubitlist.
  - No rs1/rs2 storage.
- Reset: pointers, flags and all vld bits go to 0. Outputs at reset: disp_oitf_ready=1, oitf_empty=1, all match outputs=0, dis_ptr=0, ret_ptr=0, ret_* = 0.
- Pointer flags:
  - empty when pointers and flags are equal.
  - full when pointers are equal and flags differ.
  - disp_oitf_ready = ~full. It is a pure function of registered state, with no combinational path from oitf_ret_ena.
- Alloc: on disp_oitf_ena the entry at alloc_ptr is written and its vld set on the next edge. alloc_ptr increments; the flag toggles on wrap from OITF_DEPTH-1 to 0.
- Retire: on oitf_ret_ena the entry at ret_ptr is cleared and ret_ptr increments with the same wrap rule. ret_* reflect the entry at ret_ptr combinationally.
- Alloc and retire in the same cycle: both take effect; occupancy is unchanged.
  - When full, alloc is blocked and retire proceeds.
  - When empty, retire is illegal and the new entry is not bypassed.
- Match logic: combinational over valid entries only; the entry being allocated this cycle is not compared.
  - rs1 match = OR over entries of (vld & rdwen & disp_oitf_rs1en & rdidx==disp_oitf_rs1idx). rs2 is the same with rs2en/rs2idx.
  - rd match = OR over entries of (vld & rdwen & disp_oitf_rdwen & rdidx==disp_oitf_rdidx).
  - qf match = OR over entries of (vld & qfren & disp_oitf_qfren & |(qubitlist & disp_oitf_qubitlist)).
  - An entry retiring this cycle still matches in that cycle.
- Latency: alloc is visible to match and oitf_empty one cycle after disp_oitf_ena.
- Reset asserted mid-operation clears all entries immediately (asynchronous); in-flight writebacks are discarded.
- Protocol violations (ena while full, ret while empty): behaviour undefined; the bench flags them as assertion errors.

Optional Feature:
QPU_OITF_QF_EN
- Defined: qubitlist/qfren storage, qf match and ret_qfren/ret_qubitlist are implemented.
- Undefined: that storage is removed; oitfqf_match_dispql, ret_qfren and ret_qubitlist are tied to 0; the qf input ports remain and are ignored.

Decomposition:
- Shared package/defines:
  - OITF_DEPTH and PTR_W defaults as `QPU_OITF_DEPTH and `QPU_OITF_PTR_W.
  - RFIDX and QUBIT width macros reused.
- One natural sub-module, QPU_exu_oitf_entry: it holds a single entry's vld/rdwen/rdidx/qfren/qubitlist with set and clear enables, and emits its four per-entry match terms. The top instantiates it OITF_DEPTH times in a generate loop and OR-reduces the match terms.

Test Plan:
- Reset, then idle -> ready=1, empty=1, all matches 0, dis_ptr=0, ret_ptr=0.
- Alloc rdwen=1 rdidx=5. Next cycle dispatch rs1en=1 rs1idx=5 -> oitfrd_match_disprs1=1. Retire -> match 0 the cycle after retire.
- Alloc 4 entries back to back (depth 4) -> ready=0 after 4th, dis_ptr=0 with flag toggled. Then simultaneous ena=0/ret=1 -> ready=1 next cycle, ret_ptr=1.
- At occupancy 2: simultaneous alloc and retire for 6 cycles -> occupancy stays 2, pointers wrap correctly, ret_rdidx follows allocation order.
- QF_EN: alloc qfren=1 qubitlist=0b0110. Dispatch qfren=1 qubitlist=0b0100 -> qf match 1. With 0b1001 -> 0. With qfren=0 -> 0.
- Assert rst_n low with 3 valid entries mid-cycle -> empty=1, ready=1, matches 0 without waiting for a clock edge.
